vga_timing_param: RTL and testbench

// - Parametrised VGA timing generator and pixel pipeline; next generation of the fixed-mode VGA block.
// - Generates HSYNC/VSYNC from configurable porch/sync widths and exposes X/Y pixel coordinates.
// - Issues a pixel request, accepts PIXEL one CE later and outputs COLOR/PIXEL_EN aligned with sync.
// - Sits between the framebuffer/pixel source and the board DAC pins, advancing only on the CE pixel enable.

---
 rtl/vga_timing_param.sv | 145 ++++++++++++++
 tb/tb_vga_timing_param.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_param.sv
// rtl/vga_timing_param.sv - parametrised VGA timing generator with two-stage pixel pipeline
// Optional feature: VGA_TEST_PATTERN_EN adds TP_SEL, which replaces PIXEL with an X^Y pattern.
module vga_timing_param #(
  parameter int   COLOR_W  = 8,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CNT_W    = 11
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CE,
  input  logic [COLOR_W-1:0] PIXEL,
`ifdef VGA_TEST_PATTERN_EN
  input  logic               TP_SEL,
`endif
  output logic               PIXEL_REQ,
  output logic [CNT_W-1:0]   X,
  output logic [CNT_W-1:0]   Y,
  output logic               FRAME_START,
  output logic               HSYNC,
  output logic               VSYNC,
  output logic [COLOR_W-1:0] COLOR,
  output logic               PIXEL_EN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0]   h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0]   v_cnt_q, v_cnt_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   x_q, x_d;
  logic [CNT_W-1:0]   y_q, y_d;
  logic               fs_q, fs_d;
  logic               hs1_q, hs1_d;
  logic               vs1_q, vs1_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic               en_q, en_d;
  logic               hs_q, hs_d;
  logic               vs_q, vs_d;

  logic               active;
  logic [COLOR_W-1:0] pix_src;

  assign active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);

`ifdef VGA_TEST_PATTERN_EN
  // Pattern uses the stage-1 coordinates, which line up with the pixel being captured.
  assign pix_src = TP_SEL ? COLOR_W'(x_q ^ y_q) : PIXEL;
`else
  assign pix_src = PIXEL;
`endif

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    req_d   = req_q;
    x_d     = x_q;
    y_d     = y_q;
    fs_d    = fs_q;
    hs1_d   = hs1_q;
    vs1_d   = vs1_q;
    color_d = color_q;
    en_d    = en_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    if (CE) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
      req_d = active;
      if (active) begin
        x_d = h_cnt_q;
        y_d = v_cnt_q;
      end
      fs_d  = (h_cnt_q == '0) && (v_cnt_q == '0);
      hs1_d = (h_cnt_q >= HS_BEG) && (h_cnt_q < HS_END);
      vs1_d = (v_cnt_q >= VS_BEG) && (v_cnt_q < VS_END);
      en_d    = req_q;
      color_d = req_q ? pix_src : '0;
      hs_d    = hs1_q ? HS_POL : ~HS_POL;
      vs_d    = vs1_q ? VS_POL : ~VS_POL;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
      req_q   <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      fs_q    <= 1'b0;
      hs1_q   <= 1'b0;
      vs1_q   <= 1'b0;
      color_q <= '0;
      en_q    <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
      req_q   <= req_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fs_q    <= fs_d;
      hs1_q   <= hs1_d;
      vs1_q   <= vs1_d;
      color_q <= color_d;
      en_q    <= en_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
    end
  end

  assign PIXEL_REQ   = req_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign FRAME_START = fs_q;
  assign HSYNC       = hs_q;
  assign VSYNC       = vs_q;
  assign COLOR       = color_q;
  assign PIXEL_EN    = en_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// tb/tb_vga_timing_param.sv - scoreboard bench for vga_timing_param on a 16x8 total raster
module tb_vga_timing_param;

  localparam int CW = 8;
  localparam int NW = 11;

  logic          CLK = 1'b0;
  logic          RESET;
  logic          CE;
  logic [CW-1:0] PIXEL;
  logic          TP_SEL;
  logic          PIXEL_REQ;
  logic [NW-1:0] X, Y;
  logic          FRAME_START, HSYNC, VSYNC, PIXEL_EN;
  logic [CW-1:0] COLOR;

  vga_timing_param #(
    .COLOR_W(CW), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CNT_W(NW)
  ) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .PIXEL(PIXEL),
`ifdef VGA_TEST_PATTERN_EN
    .TP_SEL(TP_SEL),
`endif
    .PIXEL_REQ(PIXEL_REQ), .X(X), .Y(Y), .FRAME_START(FRAME_START),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .COLOR(COLOR), .PIXEL_EN(PIXEL_EN)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          en;
    logic [CW-1:0] color;
    logic          hs;
    logic          vs;
  } exp_t;

  localparam exp_t RESET_E = '{en: 1'b0, color: 8'h00, hs: 1'b1, vs: 1'b1};

  exp_t sbq[$];
  exp_t last_e;
  logic last_req, last_fs;
  int   mh, mv;
  int   pix_mode;
  logic tp;
  int   compared = 0;
  int   mismatched = 0;

  function automatic logic [CW-1:0] pix_of(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    case (pix_mode)
      0:       return 8'hE0;
      1:       return xv[7:0];
      default: return {yv[3:0], xv[3:0]};
    endcase
  endfunction

  function automatic exp_t model_out(input int h, input int v);
    exp_t e;
    logic act;
    act     = (h < 8) && (v < 4);
    e.en    = act;
    e.color = act ? (tp ? 8'(h ^ v) : pix_of(h, v)) : 8'h00;
    e.hs    = (h >= 10 && h < 13) ? 1'b0 : 1'b1;
    e.vs    = (v >= 5 && v < 7) ? 1'b0 : 1'b1;
    return e;
  endfunction

  // Drives gap idle cycles (CE=0) then one CE cycle; scoreboard holds stage-2 expectations.
  task automatic sb_step(input int gap);
    exp_t e, got;
    logic act, fs;
    for (int g = 0; g < gap; g++) begin
      CE = 1'b0;
      PIXEL = 8'($urandom);
      @(posedge CLK); #1;
      got = {PIXEL_EN, COLOR, HSYNC, VSYNC};
      compared++;
      if (got !== last_e) begin
        mismatched++;
        $display("FAIL hold_stage2 got=%h exp=%h", got, last_e);
      end
      compared++;
      if ({PIXEL_REQ, FRAME_START} !== {last_req, last_fs}) begin
        mismatched++;
        $display("FAIL hold_stage1 got=%b%b exp=%b%b", PIXEL_REQ, FRAME_START, last_req, last_fs);
      end
    end
    if (tp) PIXEL = 8'($urandom);
    else    PIXEL = pix_of(int'(X), int'(Y));
    sbq.push_back(model_out(mh, mv));
    act = (mh < 8) && (mv < 4);
    fs  = (mh == 0) && (mv == 0);
    CE = 1'b1;
    @(posedge CLK); #1;
    CE = 1'b0;
    compared++;
    if (PIXEL_REQ !== act) begin
      mismatched++;
      $display("FAIL pixel_req h=%0d v=%0d got=%b exp=%b", mh, mv, PIXEL_REQ, act);
    end
    compared++;
    if (FRAME_START !== fs) begin
      mismatched++;
      $display("FAIL frame_start h=%0d v=%0d got=%b exp=%b", mh, mv, FRAME_START, fs);
    end
    if (act) begin
      compared++;
      if (X !== NW'(mh) || Y !== NW'(mv)) begin
        mismatched++;
        $display("FAIL xy got=%0d,%0d exp=%0d,%0d", X, Y, mh, mv);
      end
    end
    got = {PIXEL_EN, COLOR, HSYNC, VSYNC};
    compared++;
    if (sbq.size() == 0) begin
      mismatched++;
      $display("FAIL sb_empty got=%h exp=entry", got);
      e = RESET_E;
    end else begin
      e = sbq.pop_front();
      if (got !== e) begin
        mismatched++;
        $display("FAIL stage2 h=%0d v=%0d got=%h exp=%h", mh, mv, got, e);
      end
    end
    last_e   = e;
    last_req = act;
    last_fs  = fs;
    if (mh == 15) begin
      mh = 0;
      mv = (mv == 7) ? 0 : mv + 1;
    end else begin
      mh = mh + 1;
    end
  endtask

  task automatic model_reset();
    mh = 0;
    mv = 0;
    sbq.delete();
    sbq.push_back(RESET_E);
    last_e   = RESET_E;
    last_req = 1'b0;
    last_fs  = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    CE = 1'b0;
    PIXEL = 8'h00;
    TP_SEL = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    compared++;
    if ({PIXEL_REQ, PIXEL_EN, FRAME_START} !== 3'b000) begin
      mismatched++;
      $display("FAIL reset_flags got=%b exp=000", {PIXEL_REQ, PIXEL_EN, FRAME_START});
    end
    compared++;
    if ({HSYNC, VSYNC} !== 2'b11) begin
      mismatched++;
      $display("FAIL reset_sync got=%b exp=11", {HSYNC, VSYNC});
    end
    compared++;
    if (X !== '0 || Y !== '0 || COLOR !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_data got=%0d,%0d,%h exp=0,0,00", X, Y, COLOR);
    end
    RESET = 1'b0;
    model_reset();
    @(posedge CLK); #1;
    compared++;
    if ({PIXEL_REQ, FRAME_START, HSYNC} !== 3'b001) begin
      mismatched++;
      $display("FAIL idle_after_reset got=%b exp=001", {PIXEL_REQ, FRAME_START, HSYNC});
    end
  endtask

  task automatic test_frame_counts();
    int n_en, n_hs, n_vs, n_fs;
    n_en = 0; n_hs = 0; n_vs = 0; n_fs = 0;
    pix_mode = 0;
    for (int i = 0; i < 128; i++) begin
      sb_step(0);
      if (PIXEL_EN) n_en++;
      if (!HSYNC) n_hs++;
      if (!VSYNC) n_vs++;
      if (FRAME_START) n_fs++;
      if (!PIXEL_EN) begin
        compared++;
        if (COLOR !== 8'h00) begin
          mismatched++;
          $display("FAIL color_blank got=%h exp=00", COLOR);
        end
      end
    end
    compared++;
    if (n_en !== 32) begin mismatched++; $display("FAIL en_count got=%0d exp=32", n_en); end
    compared++;
    if (n_hs !== 24) begin mismatched++; $display("FAIL hs_count got=%0d exp=24", n_hs); end
    compared++;
    if (n_vs !== 32) begin mismatched++; $display("FAIL vs_count got=%0d exp=32", n_vs); end
    compared++;
    if (n_fs !== 1) begin mismatched++; $display("FAIL fs_count got=%0d exp=1", n_fs); end
  endtask

  task automatic test_ramp();
    int idx;
    idx = 0;
    pix_mode = 1;
    for (int i = 0; i < 128; i++) begin
      sb_step(0);
      if (PIXEL_EN) begin
        compared++;
        if (COLOR !== 8'(idx)) begin
          mismatched++;
          $display("FAIL ramp got=%h exp=%h", COLOR, 8'(idx));
        end
        idx++;
      end else begin
        idx = 0;
      end
    end
  endtask

  task automatic test_ce_gap();
    int n_en;
    n_en = 0;
    pix_mode = 2;
    for (int i = 0; i < 128; i++) begin
      sb_step(2);
      if (PIXEL_EN) n_en++;
    end
    compared++;
    if (n_en !== 32) begin mismatched++; $display("FAIL gap_en_count got=%0d exp=32", n_en); end
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    pix_mode = 1;
    while (!(mh == 5 && mv == 2) && guard < 300) begin
      sb_step(0);
      guard++;
    end
    compared++;
    if (guard >= 300) begin
      mismatched++;
      $display("FAIL reach_h5v2 got=%0d,%0d exp=5,2", mh, mv);
    end
    RESET = 1'b1;
    #2;
    compared++;
    if ({PIXEL_REQ, PIXEL_EN, FRAME_START, HSYNC, VSYNC} !== 5'b00011) begin
      mismatched++;
      $display("FAIL mid_reset_flags got=%b exp=00011",
               {PIXEL_REQ, PIXEL_EN, FRAME_START, HSYNC, VSYNC});
    end
    compared++;
    if (X !== '0 || Y !== '0 || COLOR !== 8'h00) begin
      mismatched++;
      $display("FAIL mid_reset_data got=%0d,%0d,%h exp=0,0,00", X, Y, COLOR);
    end
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    sb_step(0);
    compared++;
    if (FRAME_START !== 1'b1) begin
      mismatched++;
      $display("FAIL first_ce_fs got=%b exp=1", FRAME_START);
    end
    for (int i = 0; i < 40; i++) sb_step(0);
  endtask

`ifdef VGA_TEST_PATTERN_EN
  task automatic test_pattern();
    logic seen;
    seen = 1'b0;
    tp = 1'b1;
    TP_SEL = 1'b1;
    for (int i = 0; i < 40; i++) begin
      sb_step(0);
      // Stage-2 now shows the position two steps behind the model; (3,1) is reached at mh=5,mv=1.
      if (mh == 5 && mv == 1) begin
        seen = 1'b1;
        compared++;
        if (COLOR !== 8'h02) begin
          mismatched++;
          $display("FAIL tp_3_1 got=%h exp=02", COLOR);
        end
      end
    end
    compared++;
    if (!seen) begin mismatched++; $display("FAIL tp_reach got=0 exp=1"); end
    tp = 1'b0;
    TP_SEL = 1'b0;
  endtask
`endif

  initial begin
    tp = 1'b0;
    pix_mode = 0;
    RESET = 1'b1;
    CE = 1'b0;
    PIXEL = 8'h00;
    TP_SEL = 1'b0;
    test_reset();
    test_frame_counts();
    test_ramp();
    test_ce_gap();
    test_reset_mid();
`ifdef VGA_TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
